// File: rtl/rand_dispenser_pkg.sv
// Shared definitions for the rand_dispenser slice: LFSR geometry and the service FSM states.
package rand_dispenser_pkg;

  localparam int unsigned LFSR_W    = 9;
  localparam int unsigned REQ_IDX_W = 3;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CHECK,
    DELIVER
  } state_t;

endpackage

// File: rtl/rand_dispenser_if.sv
// Requester-side bus of rand_dispenser: per-requester request/limit in, one-hot response out.
interface rand_dispenser_if
  import rand_dispenser_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  logic [N_REQ-1:0]        req;
  logic [LFSR_W*N_REQ-1:0] limit;
  logic [N_REQ-1:0]        rsp_valid;
  logic [LFSR_W-1:0]       rsp_data;
  logic                    rsp_fallback;
  logic                    busy;

  modport master (
    output req, limit,
    input  rsp_valid, rsp_data, rsp_fallback, busy
  );

  modport slave (
    input  req, limit,
    output rsp_valid, rsp_data, rsp_fallback, busy
  );

endinterface

// File: rtl/rand_dispenser_lfsr9_step.sv
// 9-bit XNOR LFSR with step enable; the all-ones lock-up state is steered back to SEED.
module lfsr9_step
  import rand_dispenser_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 9'h00F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      if (lfsr_q == LFSR_LOCKUP) lfsr_d = SEED;
      else                       lfsr_d = {lfsr_q[LFSR_W-2:0], ~(lfsr_q[8] ^ lfsr_q[4])};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/rand_dispenser.sv
// Round-robin dispenser of bounded random values from one shared LFSR (rejection sampling).
// Build option: define RAND_DISPENSER_FREE_RUN_EN to also step the LFSR in IDLE and DELIVER.
module rand_dispenser
  import rand_dispenser_pkg::*;
#(
  parameter int unsigned       N_REQ     = 4,
  parameter int unsigned       MAX_TRIES = 4,
  parameter logic [LFSR_W-1:0] SEED      = 9'h00F
) (
  input  logic            clk,
  input  logic            reset,
  rand_dispenser_if.slave bus
);

  localparam int unsigned IW  = REQ_IDX_W;
  localparam int unsigned IW1 = REQ_IDX_W + 1;
  localparam int unsigned TW  = $clog2(MAX_TRIES + 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d, gnt_idx_c;
  logic [LFSR_W-1:0] lim_q, lim_d, res_q, res_d, gnt_lim_c, lfsr_val;
  logic [TW-1:0]     tries_q, tries_d;
  logic              fb_q, fb_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [LFSR_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_fallback_q, rsp_fallback_d, busy_q, busy_d;
  logic              gnt_found_c, step_c;
  logic [N_REQ-1:0]  req_rot_c;
  logic [IW1-1:0]    gnt_sum_c, ptr_sum_c;

  lfsr9_step #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (step_c),
    .lfsr  (lfsr_val)
  );

  // Rotate requests so bit 0 is the pointer position; first set bit wins.
  always_comb begin
    req_rot_c   = (bus.req >> ptr_q) | (bus.req << (N_REQ - 32'(ptr_q)));
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    gnt_sum_c   = '0;
    gnt_lim_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_found_c && req_rot_c[k]) begin
        gnt_found_c = 1'b1;
        gnt_sum_c   = IW1'(ptr_q) + IW1'(k);
        if (32'(gnt_sum_c) >= N_REQ) gnt_sum_c = gnt_sum_c - IW1'(N_REQ);
        gnt_idx_c   = IW'(gnt_sum_c);
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (gnt_idx_c == IW'(k)) gnt_lim_c = bus.limit[k*LFSR_W +: LFSR_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    idx_d          = idx_q;
    lim_d          = lim_q;
    tries_d        = tries_q;
    res_d          = res_q;
    fb_d           = fb_q;
    step_c         = 1'b0;
    rsp_valid_d    = '0;
    rsp_data_d     = '0;
    rsp_fallback_d = 1'b0;
    ptr_sum_c      = IW1'(idx_q) + IW1'(1);
    unique case (state_q)
      IDLE: begin
`ifdef RAND_DISPENSER_FREE_RUN_EN
        step_c = 1'b1;
`endif
        if (gnt_found_c) begin
          idx_d   = gnt_idx_c;
          lim_d   = gnt_lim_c;
          tries_d = '0;
          fb_d    = 1'b0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        step_c  = 1'b1;
        tries_d = tries_q + TW'(1);
        state_d = CHECK;
      end
      CHECK: begin
        if (lim_q == '0 || lfsr_val < lim_q) begin
          res_d   = lfsr_val;
          fb_d    = 1'b0;
          state_d = DELIVER;
        end else if (tries_q == TW'(MAX_TRIES)) begin
          res_d   = '0;
          fb_d    = 1'b1;
          state_d = DELIVER;
        end else begin
          state_d = DRAW;
        end
      end
      DELIVER: begin
`ifdef RAND_DISPENSER_FREE_RUN_EN
        step_c = 1'b1;
`endif
        rsp_valid_d    = N_REQ'(1) << idx_q;
        rsp_data_d     = res_q;
        rsp_fallback_d = fb_q;
        ptr_d          = (32'(ptr_sum_c) >= N_REQ) ? '0 : IW'(ptr_sum_c);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      lim_q          <= '0;
      tries_q        <= '0;
      res_q          <= '0;
      fb_q           <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      rsp_fallback_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      idx_q          <= idx_d;
      lim_q          <= lim_d;
      tries_q        <= tries_d;
      res_q          <= res_d;
      fb_q           <= fb_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_fallback_q <= rsp_fallback_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_fallback = rsp_fallback_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_rand_dispenser.sv
// Bench for rand_dispenser: directed scenarios plus randomized request mixes against a reference model.
module tb_rand_dispenser;
  import rand_dispenser_pkg::*;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned MAX_TRIES = 4;
  localparam int          SEED_I    = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rand_dispenser_if #(.N_REQ(N_REQ)) bus();

  rand_dispenser #(.N_REQ(N_REQ), .MAX_TRIES(MAX_TRIES), .SEED(9'h00F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int m_lfsr   = SEED_I;
  int m_ptr    = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference LFSR: shift left, XNOR of taps 8 and 4 enters at bit 0; all-ones reseeds.
  function automatic int lfsr_next(input int s);
    int fb;
    if (s == 511) return SEED_I;
    fb = (((s >> 8) & 1) == ((s >> 4) & 1)) ? 1 : 0;
    return ((s * 2) % 512) + fb;
  endfunction

  function automatic int arbitrate(input int mask, input int ptr);
    for (int k = 0; k < int'(N_REQ); k++) begin
      int i;
      i = (ptr + k) % int'(N_REQ);
      if (((mask >> i) & 1) == 1) return i;
    end
    return 0;
  endfunction

  task automatic model_serve(input int lim, output int val, output int fb, output int tries);
    val = 0; fb = 1; tries = 0;
    while (tries < int'(MAX_TRIES)) begin
      m_lfsr = lfsr_next(m_lfsr);
      tries++;
      if (lim == 0 || m_lfsr < lim) begin
        val = m_lfsr; fb = 0;
        return;
      end
    end
  endtask

  function automatic int rand_limit();
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 1;
      2:       return int'($urandom_range(2, 40));
      3:       return int'($urandom_range(400, 511));
      default: return int'($urandom_range(0, 511));
    endcase
  endfunction

  task automatic set_limit(input int i, input int v);
    bus.limit[i*LFSR_W +: LFSR_W] = 9'(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.req = '0; bus.limit = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_lfsr = SEED_I; m_ptr = 0;
  endtask

  // Called at a negedge with the DUT idle and req non-zero: the next posedge is the grant.
  task automatic serve_one(input bit perturb, output int data, output int fb, output int lat, output int vld);
    int g, lim, e_val, e_fb, e_tries, busy_bad, quiet_bad;
    g   = arbitrate(int'(bus.req), m_ptr);
    lim = int'(9'(bus.limit >> (g * LFSR_W)));
    model_serve(lim, e_val, e_fb, e_tries);
    lat = -1; data = 0; fb = 0; vld = 0; busy_bad = 0; quiet_bad = 0;
    for (int c = 1; c <= 2 * int'(MAX_TRIES) + 6; c++) begin
      @(negedge clk);
      if (perturb && c == 1) begin
        for (int i = 0; i < int'(N_REQ); i++) set_limit(i, rand_limit());
        if ($urandom_range(0, 3) == 0) bus.req = bus.req & ~(N_REQ'(1) << g);
      end
      if (bus.rsp_valid != '0) begin
        lat = c - 1; vld = int'(bus.rsp_valid);
        data = int'(bus.rsp_data); fb = int'(bus.rsp_fallback);
        break;
      end
      if (bus.busy != 1'b1) busy_bad = 1;
      if (bus.rsp_data != '0 || bus.rsp_fallback != 1'b0) quiet_bad = 1;
    end
    check_eq("latency", lat, 2 * e_tries + 1);
    check_eq("rsp_valid", vld, 1 << g);
    check_eq("rsp_data", data, e_val);
    check_eq("rsp_fallback", fb, e_fb);
    check_eq("busy_in_service", busy_bad, 0);
    check_eq("quiet_outputs", quiet_bad, 0);
    bus.req = bus.req & ~(N_REQ'(1) << g);
    m_ptr = (g + 1) % int'(N_REQ);
  endtask

  initial begin
    int d, f, l, v, seen;
    reset = 1'b1; bus.req = '0; bus.limit = '0;
    do_reset();
    check_eq("reset_rsp_valid", int'(bus.rsp_valid), 0);
    check_eq("reset_rsp_data", int'(bus.rsp_data), 0);
    check_eq("reset_fallback", int'(bus.rsp_fallback), 0);
    check_eq("reset_busy", int'(bus.busy), 0);

    // First draw accepted, then continuation with an unbounded limit.
    set_limit(0, 100); bus.req = 4'b0001;
    serve_one(1'b0, d, f, l, v);
    check_eq("tp1_data", d, 31); check_eq("tp1_lat", l, 3); check_eq("tp1_fb", f, 0);
    set_limit(0, 0); bus.req = 4'b0001;
    serve_one(1'b0, d, f, l, v);
    check_eq("tp2_data", d, 62);

    // Two held requests served in order, then the pointer sits at 2.
    do_reset();
    bus.req = 4'b0011;
    serve_one(1'b0, d, f, l, v);
    check_eq("tp3_req0_data", d, 31); check_eq("tp3_req0_vld", v, 1);
    serve_one(1'b0, d, f, l, v);
    check_eq("tp3_req1_data", d, 62); check_eq("tp3_req1_vld", v, 2);
    bus.req = 4'b0101;
    serve_one(1'b0, d, f, l, v);
    check_eq("tp3_ptr_vld", v, 4);
    serve_one(1'b0, d, f, l, v);

    // Every draw rejected: fallback after the worst-case latency.
    do_reset();
    set_limit(0, 20); bus.req = 4'b0001;
    serve_one(1'b0, d, f, l, v);
    check_eq("tp4_data", d, 0); check_eq("tp4_fb", f, 1); check_eq("tp4_lat", l, 9);

    // Repeated limit 70.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      set_limit(0, 70); bus.req = 4'b0001;
      serve_one(1'b0, d, f, l, v);
      if (r == 0) check_eq("tp5_first", d, 31);
      if (r == 1) check_eq("tp5_second", d, 62);
    end

    // Reset while in CHECK aborts service and reseeds.
    do_reset();
    set_limit(0, 0); bus.req = 4'b0001;
    repeat (2) @(negedge clk);
    reset = 1'b1; bus.req = '0;
    @(negedge clk);
    check_eq("abort_rsp_valid", int'(bus.rsp_valid), 0);
    check_eq("abort_busy", int'(bus.busy), 0);
    reset = 1'b0; m_lfsr = SEED_I; m_ptr = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1;
    end
    check_eq("abort_no_pulse", seen, 0);
    bus.req = 4'b0001;
    serve_one(1'b0, d, f, l, v);
    check_eq("abort_reseed", d, 31);

    // Randomized request mixes with mid-service limit changes and req drops.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'(N_REQ); i++) set_limit(i, rand_limit());
      bus.req = 4'($urandom_range(1, 15));
      while (bus.req != '0) serve_one(1'b1, d, f, l, v);
    end
    @(negedge clk);
    check_eq("final_idle_busy", int'(bus.busy), 0);
    check_eq("final_idle_valid", int'(bus.rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rand_dispenser.md
Name: rand_dispenser

Overview:
- Shares one 9-bit XNOR LFSR among N_REQ game requesters (falling-object spawner, column picker, delay timer) in the Canasta design.
- Requesters are served in round-robin order.
- Each request carries an exclusive upper bound. The block redraws until the value falls below that bound (rejection sampling), so every requester gets an in-range random value without its own LFSR.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_TRIES, 4, maximum draws per request before the fallback value is delivered.
- SEED, 9'h00F, LFSR value loaded on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until that requester's rsp_valid bit pulses.
- limit  in  9*N_REQ  per-requester exclusive bound, packed with requester i at [9i+8:9i]; 0 means "any value".
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse to the requester being served.
- rsp_data  out  9  delivered random value; valid only while rsp_valid is non-zero.
- rsp_fallback  out  1  high with rsp_valid when MAX_TRIES was exhausted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: LFSR=SEED, state IDLE, round-robin pointer=0, rsp_valid=0, rsp_data=0, rsp_fallback=0, busy=0.
- LFSR step rule:
  - fb = !(s[8]^s[4]); next = {s[7:0], fb}.
  - If s==9'h1FF (XNOR lock-up state), next = SEED.
  - The LFSR steps only when the FSM asserts its step signal.
- FSM states:
  - IDLE: if any req bit is set, grant the first set bit at or after the pointer (wrapping), latch its index and limit, clear the try counter, go to DRAW.
  - DRAW: step the LFSR, increment the try counter, go to CHECK.
  - CHECK: compare the stepped LFSR value against the latched limit.
    - If limit==0 or lfsr<limit: register rsp_data=lfsr, go to DELIVER.
    - Else if tries==MAX_TRIES: register rsp_data=0, set rsp_fallback, go to DELIVER.
    - Else go to DRAW.
  - DELIVER: rsp_valid[granted]=1 for exactly this cycle; pointer=(granted+1) mod N_REQ; go to IDLE.
- Outputs are registered. rsp_valid, rsp_data and rsp_fallback read 0 outside DELIVER.
- Latency: the grant edge is followed by rsp_valid on the 3rd edge after it. Each rejection adds 2 cycles. Worst case is 2*MAX_TRIES+1 cycles.
- Limit compare is an unsigned 9-bit comparison. limit==1 always yields 0.
- A requester that drops req mid-service is still served; the response is delivered and ignored.
- Changes to the latched requester's limit after the grant are ignored.
- A requester still asserting req in the cycle after its rsp_valid pulse is treated as a new request and re-arbitrated from the advanced pointer.
- Reset mid-operation aborts service, with no rsp_valid pulse. It reseeds the LFSR and zeroes the pointer.

Optional Feature:
- Macro: RAND_DISPENSER_FREE_RUN_EN.
- Defined: the LFSR also steps every cycle in IDLE and DELIVER. Values then depend on request timing. DRAW still steps exactly once.
- Undefined: the LFSR steps only in DRAW, so the value sequence is deterministic per request order. The test plan values assume undefined.

Decomposition:
- Shared package contains:
  - LFSR_W=9
  - LFSR_LOCKUP=9'h1FF
  - the state enum {IDLE, DRAW, CHECK, DELIVER}
- Sub-module lfsr9_step: holds the 9-bit register with step enable, synchronous reset to SEED, and the lock-up guard.
- The arbiter and FSM stay in rand_dispenser.

Test Plan:
- Reset, then req=4'b0001, limit0=100 → rsp_valid=4'b0001 and rsp_data=9'h01F (31) on the 3rd edge after the grant; rsp_fallback=0.
- Continuing from the state above, req0 with limit0=0 → rsp_data=9'h03E (62).
- After reset, req=4'b0011 held, all limits 0 → req0 receives 31, then req1 receives 62 in the next service; pointer advances to 2.
- After reset, limit0=20, MAX_TRIES=4 → draws 31, 62, 124 and 248 are all rejected → rsp_data=0, rsp_fallback=1, 9 cycles after the grant.
- After reset, limit0=70 → 31 accepted; then limit0=70 again → 62 accepted; then limit0=70 again → 124 rejected, 248 rejected, 9'h1F0 rejected, next draw accepted or fallback, checked against the model.
- Assert reset during CHECK → no rsp_valid pulse, busy=0 the next cycle, and the next request returns 31 again.
